i2c_slave: RTL
==============

Name: i2c_slave

Overview:
- I2C target (responder) for the same bus as the team's i2c master: decodes START/STOP, matches a 7-bit chip address, receives a register address, then writes or reads byte-wide data on a simple register-file port.
- Sits between the external SDA/SCL pads (via the same split in/out/oen pad style) and a local register bank.
- Byte-wide with register-address auto-increment, so multi-byte master transfers (e.g. 16-bit data) map to consecutive registers.

Parameters:
- ADDR_BYTES, 1, register-address bytes after chip address (0 = no register address phase; address starts at 0).
- REG_ADDR_WIDTH, 8*ADDR_BYTES, width of reg_addr (minimum 1 when ADDR_BYTES=0).

Ports:
- clk  in  1  system clock, at least 8x the SCL rate.
- reset  in  1  asynchronous, active-low reset.
- chip_addr  in  7  this target's bus address.
- scl_in  in  1  SCL from pad.
- sda_in  in  1  SDA from pad.
- sda_out  out  1  SDA output value, tied 0 (open-drain: drive only low).
- sda_oen  out  1  SDA output enable, active-low: 0 drives sda_out, 1 releases the line.
- reg_addr  out  REG_ADDR_WIDTH  current register address.
- wr_data  out  8  received data byte.
- wr_en  out  1  one-clk pulse: write wr_data to reg_addr.
- rd_req  out  1  one-clk pulse: present the byte at reg_addr.
- rd_data  in  8  read byte, valid exactly 1 clk after rd_req.
- busy  out  1  high from address match until STOP/START.
- done  out  1  one-clk pulse on STOP ending an addressed transaction.

Behaviour:
- Reset values: sda_oen=1, sda_out=0, reg_addr=0, wr_data=0, wr_en=0, rd_req=0, busy=0, done=0; state=s_idle. Reset mid-transfer releases SDA immediately.
- Input handling: scl_in and sda_in pass through 2-flop synchronizers plus a prev-sample register. Edge detection acts on the synchronized values.
- Bus conditions:
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Both are detected in any state and take priority over bit processing in the same clk.
- Bit timing: sample SDA on the SCL rising edge. Change sda_oen only on the SCL falling edge. No clock stretching.
- States:
  - s_idle: SDA released. START -> s_addr.
  - s_addr: shift in 8 bits MSB first.
    - Bits[7:1]==chip_addr -> s_addr_ack, busy=1.
    - Mismatch -> s_idle (ignore until next START).
  - s_addr_ack: drive SDA low for the 9th clock.
    - R/W=0: -> s_reg if ADDR_BYTES>0, else s_wdata. Bit counter and byte counter cleared.
    - R/W=1: pulse rd_req on the address-byte 8th rising edge, latch rd_data into the tx shift register 1 clk later, then -> s_rdata at the ACK falling edge.
  - s_reg: shift in ADDR_BYTES bytes, MSB first, into reg_addr. ACK each byte (s_reg_ack), then -> s_wdata.
  - s_wdata: shift in 8 bits, then load wr_data and pulse wr_en one clk after the 8th rising edge. ACK the byte, then increment reg_addr at the ACK falling edge.
  - s_rdata: put the tx MSB on SDA at each falling edge (oen=0 for a 0 bit, 1 for a 1 bit). Release SDA at the falling edge after bit 0 -> s_rack.
  - s_rack: sample the master ACK on the 9th rising edge.
    - ACK (0): increment reg_addr, pulse rd_req, reload the shift register, -> s_rdata.
    - NACK (1): -> s_wait.
  - s_wait: SDA released; wait for STOP/START.
- START while busy (repeated start): -> s_addr, with reg_addr retained. This supports the write-address / restart / read sequence.
- STOP: -> s_idle, busy=0. Pulse done if busy was 1.
- reg_addr increment wraps modulo 2^REG_ADDR_WIDTH (0xFF -> 0x00 for ADDR_BYTES=1).
- wr_en and rd_req are never asserted in the same clk.
- A write byte aborted by START/STOP before its 8th bit produces no wr_en.

Decomposition:
- Shared package i2c_pkg: state encodings, START/STOP condition constants, and SDA release/drive values common with the master.
- One natural sub-module, i2c_bus_sync: 2-flop synchronizers plus scl_rise, scl_fall, start_det and stop_det pulse outputs. It is reusable by the master.

Test Plan:
- Single write (chip_addr=0x50): master writes 0x50/W, reg 0x12, data 0xA5 -> three ACKs; one wr_en with reg_addr=0x12, wr_data=0xA5; done pulse on STOP.
- Burst write: reg 0xFE, data 0x11, 0x22, 0x33 -> wr_en at 0xFE, 0xFF, 0x00 (wrap) with matching data.
- Combined read: 0x50/W, reg 0x20, restart, 0x50/R, with bank returning 0x3C, 0xC3 -> bus bytes 0x3C, 0xC3; rd_req at 0x20 and 0x21; master NACK after the second byte releases SDA; done on STOP.
- Address mismatch: master addresses 0x51 -> SDA never driven, no wr_en/rd_req, busy stays 0, no done.
- Abort: STOP after 4 bits of a data byte -> no wr_en, busy=0, next START accepted normally.
- Reset mid-read while driving a 0 bit -> sda_oen=1 immediately, all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, bus-condition decode and SDA pad values.
package i2c_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StReg,
      StRegAck,
      StWdata,
      StWack,
      StRdata,
      StRack,
      StWait
   } i2c_state_e;

   typedef enum logic [1:0] {
      CondNone,
      CondStart,
      CondStop
   } bus_cond_e;

   // Open-drain pad: sda_oen=0 pulls the line to sda_out, which is always low.
   localparam logic SdaRelease = 1'b1;
   localparam logic SdaDrive   = 1'b0;
   localparam logic SdaOutLow  = 1'b0;

   function automatic bus_cond_e bus_cond(input logic scl_high, input logic sda_prev,
                                          input logic sda_now);
      if (!scl_high) return CondNone;
      if (sda_prev && !sda_now) return CondStart;
      if (!sda_prev && sda_now) return CondStop;
      return CondNone;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA with SCL edge and START/STOP pulse outputs.
module i2c_bus_sync
   import i2c_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_prev_q;
   logic       sda_prev_q;
   bus_cond_e  cond;

   // Reset to the idle-bus level so release of reset creates no false edges.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_prev_q <= scl_sync_q[1];
         sda_prev_q <= sda_sync_q[1];
      end
   end

   assign cond       = bus_cond(scl_sync_q[1] & scl_prev_q, sda_prev_q, sda_sync_q[1]);
   assign sda_o      = sda_sync_q[1];
   assign scl_rise_o = scl_sync_q[1] & ~scl_prev_q;
   assign scl_fall_o = ~scl_sync_q[1] & scl_prev_q;
   assign start_o    = (cond == CondStart);
   assign stop_o     = (cond == CondStop);

endmodule

// File: rtl/i2c_slave.sv
// I2C target: chip-address match, register-address phase, byte writes/reads on a
// register-file port with register-address auto-increment.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter int unsigned ADDR_BYTES     = 1,
   parameter int unsigned REG_ADDR_WIDTH = (ADDR_BYTES == 0) ? 1 : 8 * ADDR_BYTES
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [6:0]                chip_addr_i,
   input  logic                      scl_i,
   input  logic                      sda_i,
   output logic                      sda_o,
   output logic                      sda_oen_o,
   output logic [REG_ADDR_WIDTH-1:0] reg_addr_o,
   output logic [7:0]                wr_data_o,
   output logic                      wr_en_o,
   output logic                      rd_req_o,
   input  logic [7:0]                rd_data_i,
   output logic                      busy_o,
   output logic                      done_o
);

   localparam logic [7:0] LastAddrByte = 8'((ADDR_BYTES == 0) ? 0 : ADDR_BYTES - 1);

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   i2c_bus_sync u_sync (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_det),
      .stop_o     (stop_det)
   );

   i2c_state_e                state_q;
   logic [3:0]                bit_cnt_q;
   logic [7:0]                byte_cnt_q;
   logic [7:0]                rx_q;
   logic [7:0]                tx_q;
   logic                      rw_q;
   logic                      rd_pend_q;
   logic                      wr_pend_q;
   logic                      oen_q;
   logic [REG_ADDR_WIDTH-1:0] reg_addr_q;
   logic [7:0]                wr_data_q;
   logic                      wr_en_q;
   logic                      rd_req_q;
   logic                      busy_q;
   logic                      done_q;

   logic [7:0]                rx_next;
   logic [REG_ADDR_WIDTH-1:0] reg_addr_shift;
   logic [REG_ADDR_WIDTH-1:0] reg_addr_inc;

   assign rx_next        = {rx_q[6:0], sda_s};
   assign reg_addr_shift = (reg_addr_q << 1) | REG_ADDR_WIDTH'(sda_s);
   assign reg_addr_inc   = reg_addr_q + REG_ADDR_WIDTH'(1);

   // In the ACK states oen_q doubles as the phase flag: released = ACK not yet driven.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         rw_q       <= 1'b0;
         rd_pend_q  <= 1'b0;
         wr_pend_q  <= 1'b0;
         oen_q      <= SdaRelease;
         reg_addr_q <= '0;
         wr_data_q  <= '0;
         wr_en_q    <= 1'b0;
         rd_req_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         wr_en_q   <= 1'b0;
         rd_req_q  <= 1'b0;
         done_q    <= 1'b0;
         wr_pend_q <= 1'b0;
         // Read data is valid the clk after rd_req is seen by the bank.
         rd_pend_q <= rd_req_q;
         if (rd_pend_q) tx_q <= rd_data_i;
         if (wr_pend_q) begin
            wr_data_q <= rx_q;
            wr_en_q   <= 1'b1;
         end

         if (start_det) begin
            state_q   <= StAddr;
            bit_cnt_q <= '0;
            oen_q     <= SdaRelease;
            busy_q    <= 1'b0;
         end else if (stop_det) begin
            state_q <= StIdle;
            oen_q   <= SdaRelease;
            busy_q  <= 1'b0;
            done_q  <= busy_q;
         end else begin
            unique case (state_q)
               StIdle, StWait: ;
               StAddr: if (scl_rise) begin
                  rx_q      <= rx_next;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (rx_next[7:1] == chip_addr_i) begin
                        state_q  <= StAddrAck;
                        busy_q   <= 1'b1;
                        rw_q     <= rx_next[0];
                        rd_req_q <= rx_next[0];
                     end else begin
                        state_q <= StIdle;
                     end
                  end
               end
               StAddrAck: if (scl_fall) begin
                  if (oen_q == SdaRelease) begin
                     oen_q <= SdaDrive;
                  end else begin
                     byte_cnt_q <= '0;
                     if (rw_q) begin
                        oen_q     <= tx_q[7];
                        tx_q      <= {tx_q[6:0], 1'b0};
                        bit_cnt_q <= 4'd1;
                        state_q   <= StRdata;
                     end else begin
                        oen_q     <= SdaRelease;
                        bit_cnt_q <= '0;
                        state_q   <= (ADDR_BYTES > 0) ? StReg : StWdata;
                     end
                  end
               end
               StReg: if (scl_rise) begin
                  reg_addr_q <= reg_addr_shift;
                  bit_cnt_q  <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) state_q <= StRegAck;
               end
               StRegAck: if (scl_fall) begin
                  if (oen_q == SdaRelease) begin
                     oen_q <= SdaDrive;
                  end else begin
                     oen_q      <= SdaRelease;
                     bit_cnt_q  <= '0;
                     byte_cnt_q <= byte_cnt_q + 8'd1;
                     state_q    <= (byte_cnt_q == LastAddrByte) ? StWdata : StReg;
                  end
               end
               StWdata: if (scl_rise) begin
                  rx_q      <= rx_next;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     wr_pend_q <= 1'b1;
                     state_q   <= StWack;
                  end
               end
               StWack: if (scl_fall) begin
                  if (oen_q == SdaRelease) begin
                     oen_q <= SdaDrive;
                  end else begin
                     oen_q      <= SdaRelease;
                     reg_addr_q <= reg_addr_inc;
                     bit_cnt_q  <= '0;
                     state_q    <= StWdata;
                  end
               end
               StRdata: if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     oen_q   <= SdaRelease;
                     state_q <= StRack;
                  end else begin
                     oen_q     <= tx_q[7];
                     tx_q      <= {tx_q[6:0], 1'b0};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
               end
               StRack: if (scl_rise) begin
                  if (!sda_s) begin
                     reg_addr_q <= reg_addr_inc;
                     rd_req_q   <= 1'b1;
                     bit_cnt_q  <= '0;
                     state_q    <= StRdata;
                  end else begin
                     state_q <= StWait;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign sda_o      = SdaOutLow;
   assign sda_oen_o  = oen_q;
   assign reg_addr_o = reg_addr_q;
   assign wr_data_o  = wr_data_q;
   assign wr_en_o    = wr_en_q;
   assign rd_req_o   = rd_req_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule
